// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, default queue depth
// and the launch FSM state encoding.
package uart_pkg;

  localparam int UART_BYTE_W   = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/byte_fifo.sv
// Generic synchronous byte FIFO: circular buffer with free-running pointers and a
// separate occupancy counter. A push into a full FIFO is accepted only alongside a pop.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic [UART_BYTE_W-1:0] pop_data_o,
  output logic                   push_ok_o,
  output logic [ADDR_W:0]        count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign pop_ok     = pop_i && !empty_o;
  // When full, wr_ptr == rd_ptr; the popped byte is read before this edge overwrites it.
  assign push_ok_o  = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok_o ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok_o, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push_ok_o) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of the UART sender: buffers bus writes and launches
// them one frame at a time, holding tx_data stable for the whole frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   clr_ovf,
  input  logic                   tx_status,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_en,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   tx_done,
  output logic [1:0]             dbg_state
);

  // Sender handshake: tx_en is a one-cycle launch strobe qualified by tx_data; the
  // sender answers by dropping tx_status (busy) and raising it again at end of frame.
  logic [1:0]             state_q, state_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_en_q, tx_en_d;
  logic                   tx_done_q, tx_done_d;
  logic                   ovf_q, ovf_d;
  logic                   pop;
  logic                   push_ok;
  logic [UART_BYTE_W-1:0] fifo_data;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .CLK         (CLK),
    .Reset       (Reset),
    .push_i      (wr_en),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .push_ok_o   (push_ok),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign pop = (state_q == ST_IDLE) && !empty && tx_status;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    tx_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d = fifo_data;
          tx_en_d   = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_status) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (tx_status) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // A dropped push outranks a same-cycle clear so no loss goes unreported.
  assign ovf_d = (wr_en && !push_ok) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_done_q <= tx_done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;
  assign tx_done   = tx_done_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: sender model plus byte scoreboard, a vector table for the
// full/overflow corner, hand-written multi-cycle sequences and a random stream.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_ovf = 1'b0;
  logic              tx_status = 1'b1;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_done;
  logic [1:0]        dbg_state;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_done   (tx_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // sender model state
  int   frame_len = 3;
  bit   rand_len = 1'b0;
  bit   hold_busy = 1'b0;
  int   busy_cnt = 0;
  bit   pend = 1'b0;
  bit   frame_open = 1'b0;
  bit   prev_en = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int   launches = 0;
  int   dones = 0;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         clr;
    int         cnt;
    bit         full;
    bit         ovf;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_cycle(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && dbg_state == ST_IDLE && empty && !frame_open) && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 1);
  endtask

  // sender model + scoreboard, evaluated 1 time unit after each edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (Reset) begin
        busy_cnt   = 0;
        pend       = 1'b0;
        frame_open = 1'b0;
        prev_en    = 1'b0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        else if (pend) begin
          pend     = 1'b0;
          busy_cnt = rand_len ? int'($urandom_range(1, 6)) : frame_len;
        end
        if (tx_en) begin
          check("tx_en_one_cycle", 32'(prev_en), 0);
          check("tx_en_after_prev_done", 32'(frame_open), 0);
          if (exp_q.size() == 0) check("tx_en_unexpected", 32'(tx_en), 0);
          else check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
          frame_open = 1'b1;
          last_byte  = tx_data;
          pend       = 1'b1;
          launches++;
        end else if (frame_open) begin
          check("tx_data_held", 32'(tx_data), 32'(last_byte));
        end
        if (tx_done) begin
          check("tx_done_in_frame", 32'(frame_open), 1);
          frame_open = 1'b0;
          dones++;
        end
        prev_en = tx_en;
      end
      tx_status = !hold_busy && busy_cnt == 0 && !pend;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;
    int sent;
    int guard;
    int max_cnt;
    int d0;
    logic [7:0] b;

    for (int i = 0; i < 18; i++) begin
      vecs[i].wr   = 1'b1;
      vecs[i].d    = 8'(8'h10 + i);
      vecs[i].clr  = 1'b0;
      vecs[i].cnt  = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      vecs[i].full = (i >= DEPTH - 1);
      vecs[i].ovf  = (i >= DEPTH);
    end
    vecs[18] = '{wr: 1'b0, d: 8'h00, clr: 1'b1, cnt: DEPTH, full: 1'b1, ovf: 1'b0};
    vecs[19] = '{wr: 1'b1, d: 8'hEE, clr: 1'b1, cnt: DEPTH, full: 1'b1, ovf: 1'b1};
    vecs[20] = '{wr: 1'b0, d: 8'h00, clr: 1'b1, cnt: DEPTH, full: 1'b1, ovf: 1'b0};

    // reset state
    repeat (2) @(posedge CLK);
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    Reset = 1'b0;
    cycle();

    // single byte: latency and one tx_done after a 100-cycle frame
    frame_len = 100;
    exp_q.push_back(8'hA5);
    push_cycle(8'hA5);
    check("single_count_1", 32'(count), 1);
    check("single_empty_0", 32'(empty), 0);
    check("single_no_early_en", 32'(tx_en), 0);
    cycle();
    check("single_tx_en", 32'(tx_en), 1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_count_0", 32'(count), 0);
    cycle();
    check("single_tx_en_low", 32'(tx_en), 0);
    d0 = dones;
    repeat (98) cycle();
    check("single_no_early_done", 32'(dones - d0), 0);
    repeat (12) cycle();
    check("single_done_once", 32'(dones - d0), 1);

    // burst of five
    frame_len = 3;
    base = launches;
    d0 = dones;
    max_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push_cycle(8'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    wait_drain(200, "burst");
    check("burst_launches", 32'(launches - base), 5);
    check("burst_dones", 32'(dones - d0), 5);
    check("burst_peak", 32'(max_cnt == 4 || max_cnt == 5), 1);
    check("burst_end_count", 32'(count), 0);

    // full / overflow table with the sender held busy
    hold_busy = 1'b1;
    repeat (3) cycle();
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr && i < DEPTH) exp_q.push_back(vecs[i].d);
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].d;
      clr_ovf = vecs[i].clr;
      cycle();
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_no_en", i), 32'(tx_en), 0);
    end

    // push on the exact cycle of a pop while full
    base = launches;
    hold_busy = 1'b0;
    guard = 0;
    while (!tx_status && guard < 5) begin
      cycle();
      guard++;
    end
    check("simul_status_up", 32'(tx_status), 1);
    exp_q.push_back(8'h77);
    push_cycle(8'h77);
    check("simul_tx_en", 32'(tx_en), 1);
    check("simul_count", 32'(count), DEPTH);
    check("simul_full", 32'(full), 1);
    check("simul_ovf", 32'(overflow), 0);
    frame_len = 2;
    wait_drain(400, "full");
    check("full_launches", 32'(launches - base), 17);
    check("full_ovf_end", 32'(overflow), 0);

    // random stream across pointer wrap
    rand_len = 1'b1;
    base = launches;
    acc = 0;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 3000) begin
      if ($urandom_range(0, 2) != 0 && (acc - (launches - base)) < DEPTH) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        wr_en   = 1'b1;
        wr_data = b;
        acc++;
        sent++;
      end
      cycle();
      wr_en = 1'b0;
      check("wrap_count", 32'(count), 32'(acc - (launches - base)));
      guard++;
    end
    wait_drain(400, "wrap");
    check("wrap_launches", 32'(launches - base), 40);
    check("wrap_ovf", 32'(overflow), 0);
    rand_len = 1'b0;

    // reset in WAIT_DONE with three bytes queued
    frame_len = 100;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'hC0 + i));
      push_cycle(8'(8'hC0 + i));
    end
    guard = 0;
    while (dbg_state != ST_WAIT_DONE && guard < 20) begin
      cycle();
      guard++;
    end
    check("midrst_in_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    check("midrst_queued", 32'(count), 3);
    Reset = 1'b1;
    #1;
    check("midrst_empty", 32'(empty), 1);
    check("midrst_count", 32'(count), 0);
    check("midrst_tx_en", 32'(tx_en), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    repeat (2) cycle();
    Reset = 1'b0;
    base = launches;
    repeat (30) cycle();
    check("midrst_no_launch", 32'(launches - base), 0);
    check("midrst_still_empty", 32'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the CPU-side UART register interface and the serial sender.
- Accepts byte writes from the bus side, queues them, and launches them one at a time into the sender through its txdata/txen/txstatus handshake.
- Holds the outgoing byte stable for the whole frame.
- Lets software push a burst without polling the sender's busy bit per byte.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4: log2(DEPTH); pointer width.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request, sampled on the CLK rising edge.
- wr_data  input  8  byte to push.
- clr_ovf  input  1  clears the overflow flag.
- tx_status  input  1  from sender; 1 = idle, 0 = transmitting.
- tx_data  output  8  byte presented to the sender's txdata.
- tx_en  output  1  one-cycle launch pulse to the sender's txen.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a push was dropped.
- tx_done  output  1  one-cycle pulse when a launched byte has finished.

Behaviour:
- Reset (asynchronous, any state):
  - pointers and count = 0, FSM = IDLE.
  - tx_data = 8'h00, tx_en = 0, tx_done = 0, overflow = 0.
  - empty = 1, full = 0.
  - Storage contents are don't-care.
- Storage: circular buffer with rd_ptr and wr_ptr of ADDR_W bits; both wrap modulo DEPTH naturally. count is a separate ADDR_W+1 register.
- Push accepted when wr_en = 1 and (not full, or a pop occurs in the same cycle).
  - Accepted push: mem[wr_ptr] <= wr_data, wr_ptr + 1.
- Push rejected when wr_en = 1, full = 1 and no pop that cycle.
  - Data is dropped; overflow <= 1.
- overflow stays set until clr_ovf = 1. If clr_ovf and a dropped push occur in the same cycle, set wins.
- count update per cycle:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- full and empty are decoded combinationally from count.
- FSM, all outputs registered:
  - IDLE: if not empty and tx_status = 1, pop (tx_data <= mem[rd_ptr], rd_ptr + 1) and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_en = 1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_status = 0, then go to WAIT_DONE. The sender drops txstatus the cycle after txen.
  - WAIT_DONE: when tx_status = 1, pulse tx_done for one cycle and go to IDLE.
- tx_data changes only on a pop; it is held through WAIT_BUSY and WAIT_DONE.
- Latency: a push at edge N into an empty FIFO with the sender idle produces:
  - empty = 0 after edge N
  - pop at edge N+1
  - tx_en high during cycle N+1 to N+2
- Back-to-back bytes: the next pop happens on the first IDLE cycle after tx_done. There is at most one pop per frame.
- If tx_status is 0 while the FSM is in IDLE (sender busy from another source), no pop occurs; the FSM waits.
- Reset mid-frame returns the FSM to IDLE immediately and discards queued bytes. The sender shares the reset source and aborts too.

Decomposition:
- Shared package uart_pkg holds:
  - UART_BYTE_W = 8
  - FSM state encoding: IDLE = 2'd0, LAUNCH = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3
  - default DEPTH
- One sub-module is natural: byte_fifo, a generic synchronous FIFO with push/pop/count/full/empty.
- uart_tx_fifo wraps byte_fifo and adds the launch FSM and the overflow flag.

Test Plan:
- Single byte: after reset, push 8'hA5 with tx_status = 1.
  - tx_en is a single one-cycle pulse two edges later, with tx_data = 8'hA5.
  - count goes 1 then 0.
  - The sender model holds tx_status = 0 for 100 cycles; tx_done pulses once when it rises.
- Burst: push 8'h01..8'h05 on consecutive cycles.
  - Exactly five tx_en pulses, in order 01..05.
  - Each pulse occurs only after the previous tx_done.
  - count peaks at 4 or 5 and ends at 0.
- Full and overflow: hold tx_status = 0, push DEPTH+2 bytes.
  - full = 1 at count 16; overflow = 1; count stays 16.
  - Release tx_status: the 16 first-written bytes emerge in order.
  - clr_ovf clears overflow.
- Simultaneous push and pop when full: on the cycle the FSM pops, push 8'h77.
  - Push accepted, count stays 16, overflow stays 0.
  - 8'h77 emerges last.
- Pointer wrap: stream 40 bytes with a random idle sender.
  - Output sequence equals input sequence; no loss; overflow = 0.
- Reset mid-frame: assert Reset during WAIT_DONE with 3 bytes queued.
  - Immediately: empty = 1, count = 0, tx_en = 0, tx_data = 8'h00.
  - After release with no pushes, no tx_en pulse appears.
